ibex_instr_realigner: RTL and testbench

- Sequences the raw fetch stream into whole instructions for the compressed decoder and the main decoder.
- Accepts word-aligned 32-bit fetch words and buffers one word plus one stashed halfword.
- Emits one instruction per handshake, aligned to bit 0, with its PC, a compressed flag and an error flag.
- Handles 32-bit instructions that straddle a word boundary, and redirects to halfword-aligned targets.

---
 rtl/ibex_pkg.sv | 19 +
 rtl/ibex_instr_realigner.sv | 182 ++++++++++++++++++
 tb/tb_ibex_instr_realigner.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the instruction fetch realigner.
// Holds the realigner state enum and a compressed-opcode helper.
package ibex_pkg;

  typedef enum logic [2:0] {
    REALIGN_EMPTY,
    REALIGN_LO,
    REALIGN_HI,
    REALIGN_SPAN_WAIT,
    REALIGN_SPAN
  } realign_state_e;

  localparam logic [31:0] REALIGN_BOOT_ADDR = 32'h0000_0080;

  function automatic logic realign_is_rvc(input logic [1:0] op);
    return op != 2'b11;
  endfunction

endpackage

// File: rtl/ibex_instr_realigner.sv
// Instruction realigner: turns word-aligned fetch words into whole
// instructions (aligned to bit 0) with PC, compressed and error flags.
// Ports: clk_i/rst_i (sync, active-high); fetch_* word handshake;
//   redirect_i/redirect_pc_i flush; instr_* instruction handshake.
// Macro IBEX_REALIGN_RVC_EN enables halfword realignment; when
// undefined every word is issued whole with pc+=4.
module ibex_instr_realigner
  import ibex_pkg::*;
#(
  parameter logic [31:0] BootAddr = REALIGN_BOOT_ADDR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_is_compressed_o,
  output logic        instr_err_o
);

  realign_state_e r_state, w_state_d;

  logic [31:0] r_word, w_word_d;
  logic        r_werr, w_werr_d;
  logic [31:0] r_pc, w_pc_d;

  logic        w_valid;
  logic        w_fready;
  logic [31:0] w_rdata;
  logic        w_err;
  logic [31:0] w_inc;

`ifdef IBEX_REALIGN_RVC_EN
  logic [15:0] r_hw, w_hw_d;
  logic        r_hwerr, w_hwerr_d;
  logic        r_skip_lo, w_skip_d;
  logic        w_unused_pc;
  assign w_unused_pc = redirect_pc_i[0];
`else
  logic [1:0]  w_unused_pc;
  assign w_unused_pc = redirect_pc_i[1:0];
`endif

  always_comb begin
    w_state_d = r_state;
    w_word_d  = r_word;
    w_werr_d  = r_werr;
    w_pc_d    = r_pc;
    w_valid   = 1'b0;
    w_fready  = 1'b0;
    w_rdata   = r_word;
    w_err     = r_werr;
    w_inc     = 32'd4;
`ifdef IBEX_REALIGN_RVC_EN
    w_hw_d    = r_hw;
    w_hwerr_d = r_hwerr;
    w_skip_d  = r_skip_lo;
`endif
    // Redirect beats every handshake; reset also forces idle outputs.
    if (rst_i || redirect_i) begin
      w_state_d = REALIGN_EMPTY;
`ifdef IBEX_REALIGN_RVC_EN
      w_pc_d    = {redirect_pc_i[31:1], 1'b0};
      w_skip_d  = redirect_pc_i[1];
`else
      w_pc_d    = {redirect_pc_i[31:2], 2'b00};
`endif
    end else begin
      unique case (r_state)
        REALIGN_EMPTY: begin
          w_fready = 1'b1;
          if (fetch_valid_i) begin
`ifdef IBEX_REALIGN_RVC_EN
            w_state_d = r_skip_lo ? REALIGN_HI : REALIGN_LO;
`else
            w_state_d = REALIGN_LO;
`endif
          end
        end
        REALIGN_LO: begin
          w_valid = 1'b1;
`ifdef IBEX_REALIGN_RVC_EN
          if (realign_is_rvc(r_word[1:0])) begin
            w_rdata = {16'h0, r_word[15:0]};
            w_inc   = 32'd2;
            if (instr_ready_i) w_state_d = REALIGN_HI;
          end else
`endif
          begin
            w_fready = instr_ready_i;
            if (instr_ready_i)
              w_state_d = fetch_valid_i ? REALIGN_LO
                                        : REALIGN_EMPTY;
          end
        end
`ifdef IBEX_REALIGN_RVC_EN
        REALIGN_HI: begin
          if (realign_is_rvc(r_word[17:16])) begin
            w_valid  = 1'b1;
            w_rdata  = {16'h0, r_word[31:16]};
            w_inc    = 32'd2;
            w_fready = instr_ready_i;
            if (instr_ready_i)
              w_state_d = fetch_valid_i ? REALIGN_LO
                                        : REALIGN_EMPTY;
          end else begin
            // Upper half starts a 32-bit instr: stash it, fetch more.
            w_hw_d    = r_word[31:16];
            w_hwerr_d = r_werr;
            w_fready  = 1'b1;
            w_state_d = fetch_valid_i ? REALIGN_SPAN
                                      : REALIGN_SPAN_WAIT;
          end
        end
        REALIGN_SPAN_WAIT: begin
          w_fready = 1'b1;
          if (fetch_valid_i) w_state_d = REALIGN_SPAN;
        end
        REALIGN_SPAN: begin
          w_valid = 1'b1;
          w_rdata = {r_word[15:0], r_hw};
          w_err   = r_hwerr | r_werr;
          if (instr_ready_i) w_state_d = REALIGN_HI;
        end
`endif
        default: w_state_d = REALIGN_EMPTY;
      endcase

      if (w_fready && fetch_valid_i) begin
        w_word_d = fetch_rdata_i;
        w_werr_d = fetch_err_i;
`ifdef IBEX_REALIGN_RVC_EN
        w_skip_d = 1'b0;
`endif
      end
      if (w_valid && instr_ready_i) w_pc_d = r_pc + w_inc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= REALIGN_EMPTY;
      r_word  <= '0;
      r_werr  <= 1'b0;
      r_pc    <= BootAddr;
`ifdef IBEX_REALIGN_RVC_EN
      r_hw      <= '0;
      r_hwerr   <= 1'b0;
      r_skip_lo <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      r_word  <= w_word_d;
      r_werr  <= w_werr_d;
      r_pc    <= w_pc_d;
`ifdef IBEX_REALIGN_RVC_EN
      r_hw      <= w_hw_d;
      r_hwerr   <= w_hwerr_d;
      r_skip_lo <= w_skip_d;
`endif
    end
  end

  assign fetch_ready_o = w_fready;
  assign instr_valid_o = w_valid;
  assign instr_rdata_o = w_rdata;
  assign instr_pc_o    = r_pc;
  assign instr_err_o   = w_err;
`ifdef IBEX_REALIGN_RVC_EN
  assign instr_is_compressed_o = realign_is_rvc(w_rdata[1:0]);
`else
  assign instr_is_compressed_o = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_instr_realigner.sv
// Self-checking bench for ibex_instr_realigner (both RVC builds).
// Expected instructions are queued as stimulus is built.
module tb_ibex_instr_realigner;

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] pc;
    logic        c;
    logic        e;
  } exp_t;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } fw_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        fetch_valid_i = 1'b0;
  logic        fetch_ready_o;
  logic [31:0] fetch_rdata_i = '0;
  logic        fetch_err_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b1;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_pc_o;
  logic        instr_is_compressed_o;
  logic        instr_err_o;

  exp_t sb[$];
  fw_t  fq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  ibex_instr_realigner dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .fetch_valid_i         (fetch_valid_i),
    .fetch_ready_o         (fetch_ready_o),
    .fetch_rdata_i         (fetch_rdata_i),
    .fetch_err_i           (fetch_err_i),
    .redirect_i            (redirect_i),
    .redirect_pc_i         (redirect_pc_i),
    .instr_valid_o         (instr_valid_o),
    .instr_ready_i         (instr_ready_i),
    .instr_rdata_o         (instr_rdata_o),
    .instr_pc_o            (instr_pc_o),
    .instr_is_compressed_o (instr_is_compressed_o),
    .instr_err_o           (instr_err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic exp_t mk(logic [31:0] d, logic [31:0] pc,
                              logic c, logic e);
    return {d, pc, c, e};
  endfunction

  task automatic push_fw(logic [31:0] d, logic e);
    fq.push_back({d, e});
  endtask

  task automatic drive_fetch();
    if (fq.size() > 0) begin
      fetch_valid_i = 1'b1;
      fetch_rdata_i = fq[0].d;
      fetch_err_i   = fq[0].e;
    end else begin
      fetch_valid_i = 1'b0;
      fetch_rdata_i = '0;
      fetch_err_i   = 1'b0;
    end
  endtask

  // Called just after a negedge: pops the word the DUT takes at
  // the coming posedge and presents the next one.
  task automatic advance();
    logic fx;
    fx = fetch_valid_i && fetch_ready_o;
    @(posedge clk_i);
    #1;
    if (fx && fq.size() > 0) void'(fq.pop_front());
    drive_fetch();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    redirect_i = 1'b0;
    instr_ready_i = 1'b1;
    fq.delete();
    sb.delete();
    drive_fetch();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h00A0_0513;
    instr_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_chk++;
    if (instr_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset valid: got %b want 0", instr_valid_o);
    end
    n_chk++;
    if (fetch_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset fready: got %b want 0", fetch_ready_o);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    fetch_valid_i = 1'b0;
    @(negedge clk_i);
    n_chk++;
    if (instr_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL empty valid: got %b want 0", instr_valid_o);
    end
    n_chk++;
    if (fetch_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL empty fready: got %b want 1", fetch_ready_o);
    end
  endtask

  task automatic test_back_to_back();
    exp_t o, e;
    int t[$];
    int gap;
    do_reset();
    push_fw(32'h00A0_0513, 1'b0);
    push_fw(32'h0010_0093, 1'b0);
    sb.push_back(mk(32'h00A0_0513, 32'h80, 1'b0, 1'b0));
    sb.push_back(mk(32'h0010_0093, 32'h84, 1'b0, 1'b0));
    drive_fetch();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (instr_valid_o && instr_ready_i) begin
        n_chk++;
        t.push_back(c);
        o = {instr_rdata_o, instr_pc_o,
             instr_is_compressed_o, instr_err_o};
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL b2b instr: got %h want %h", o, e);
        end
      end
      advance();
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b drain: got %0d left want 0", sb.size());
    end
    gap = (t.size() == 2) ? t[1] - t[0] : -1;
    n_chk++;
    if (gap != 1) begin
      n_fail++;
      $display("FAIL b2b gap: got %0d want 1", gap);
    end
  endtask

  task automatic test_stall();
    exp_t o, e;
    do_reset();
    instr_ready_i = 1'b0;
    push_fw(32'h00A0_0513, 1'b0);
    push_fw(32'h0010_0093, 1'b0);
    drive_fetch();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      if (c >= 1) begin
        n_chk++;
        if ({instr_valid_o, fetch_ready_o, instr_rdata_o} !==
            {1'b1, 1'b0, 32'h00A0_0513}) begin
          n_fail++;
          $display("FAIL stall hold: got v=%b fr=%b d=%h want 1 0 00a00513",
                   instr_valid_o, fetch_ready_o, instr_rdata_o);
        end
      end
      advance();
    end
    instr_ready_i = 1'b1;
    sb.push_back(mk(32'h00A0_0513, 32'h80, 1'b0, 1'b0));
    sb.push_back(mk(32'h0010_0093, 32'h84, 1'b0, 1'b0));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (instr_valid_o && instr_ready_i) begin
        n_chk++;
        o = {instr_rdata_o, instr_pc_o,
             instr_is_compressed_o, instr_err_o};
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL stall instr: got %h want %h", o, e);
        end
      end
      advance();
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL stall drain: got %0d left want 0", sb.size());
    end
  endtask

  task automatic test_compressed();
    exp_t o, e;
    do_reset();
    push_fw(32'h4501_4505, 1'b0);
    push_fw(32'h0010_0093, 1'b0);
`ifdef IBEX_REALIGN_RVC_EN
    sb.push_back(mk(32'h0000_4505, 32'h80, 1'b1, 1'b0));
    sb.push_back(mk(32'h0000_4501, 32'h82, 1'b1, 1'b0));
`else
    sb.push_back(mk(32'h4501_4505, 32'h80, 1'b0, 1'b0));
`endif
    sb.push_back(mk(32'h0010_0093, 32'h84, 1'b0, 1'b0));
    drive_fetch();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (instr_valid_o && instr_ready_i) begin
        n_chk++;
        o = {instr_rdata_o, instr_pc_o,
             instr_is_compressed_o, instr_err_o};
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL rvc instr: got %h want %h", o, e);
        end
      end
      advance();
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL rvc drain: got %0d left want 0", sb.size());
    end
    n_chk++;
    if (fetch_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rvc idle fready: got %b want 1", fetch_ready_o);
    end
  endtask

`ifdef IBEX_REALIGN_RVC_EN
  task automatic test_straddle();
    exp_t o, e;
    int t[$];
    int gap;
    do_reset();
    push_fw(32'h0513_4505, 1'b0);
    push_fw(32'h0000_00A0, 1'b0);
    sb.push_back(mk(32'h0000_4505, 32'h80, 1'b1, 1'b0));
    sb.push_back(mk(32'h00A0_0513, 32'h82, 1'b0, 1'b0));
    sb.push_back(mk(32'h0000_0000, 32'h86, 1'b1, 1'b0));
    drive_fetch();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (instr_valid_o && instr_ready_i) begin
        n_chk++;
        t.push_back(c);
        o = {instr_rdata_o, instr_pc_o,
             instr_is_compressed_o, instr_err_o};
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL span instr: got %h want %h", o, e);
        end
      end
      advance();
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL span drain: got %0d left want 0", sb.size());
    end
    gap = (t.size() == 3) ? t[1] - t[0] : -1;
    n_chk++;
    if (gap != 2) begin
      n_fail++;
      $display("FAIL span bubble: got gap %0d want 2", gap);
    end
  endtask
`endif

  task automatic test_redirect();
    exp_t o, e;
    do_reset();
    instr_ready_i = 1'b0;
    push_fw(32'h00A0_0513, 1'b0);
    push_fw(32'h0010_0093, 1'b0);
    drive_fetch();
    @(negedge clk_i);
    advance();
    n_chk++;
    if (instr_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pre-redirect valid: got %b want 1", instr_valid_o);
    end
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0102;
    instr_ready_i = 1'b1;
    @(negedge clk_i);
    n_chk++;
    if ({instr_valid_o, fetch_ready_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL redirect cycle: got v=%b fr=%b want 0 0",
               instr_valid_o, fetch_ready_o);
    end
    advance();
    redirect_i = 1'b0;
    fq.delete();
    push_fw(32'h4505_0001, 1'b0);
`ifdef IBEX_REALIGN_RVC_EN
    sb.push_back(mk(32'h0000_4505, 32'h102, 1'b1, 1'b0));
`else
    sb.push_back(mk(32'h4505_0001, 32'h100, 1'b0, 1'b0));
`endif
    drive_fetch();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (instr_valid_o && instr_ready_i) begin
        n_chk++;
        o = {instr_rdata_o, instr_pc_o,
             instr_is_compressed_o, instr_err_o};
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL redirect instr: got %h want %h", o, e);
        end
      end
      advance();
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL redirect drain: got %0d left want 0", sb.size());
    end
  endtask

  task automatic test_error();
    exp_t o, e;
    do_reset();
    push_fw(32'h0513_4505, 1'b0);
    push_fw(32'h0000_00A0, 1'b1);
    push_fw(32'h0010_0093, 1'b0);
`ifdef IBEX_REALIGN_RVC_EN
    sb.push_back(mk(32'h0000_4505, 32'h80, 1'b1, 1'b0));
    sb.push_back(mk(32'h00A0_0513, 32'h82, 1'b0, 1'b1));
    sb.push_back(mk(32'h0000_0000, 32'h86, 1'b1, 1'b1));
`else
    sb.push_back(mk(32'h0513_4505, 32'h80, 1'b0, 1'b0));
    sb.push_back(mk(32'h0000_00A0, 32'h84, 1'b0, 1'b1));
`endif
    sb.push_back(mk(32'h0010_0093, 32'h88, 1'b0, 1'b0));
    drive_fetch();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk_i);
      if (instr_valid_o && instr_ready_i) begin
        n_chk++;
        o = {instr_rdata_o, instr_pc_o,
             instr_is_compressed_o, instr_err_o};
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL err instr: got %h want %h", o, e);
        end
      end
      advance();
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL err drain: got %0d left want 0", sb.size());
    end
  endtask

  task automatic test_wrap();
    exp_t o, e;
    do_reset();
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    @(posedge clk_i);
    #1;
    redirect_i = 1'b0;
    push_fw(32'h00A0_0513, 1'b0);
    push_fw(32'h0010_0093, 1'b0);
    sb.push_back(mk(32'h00A0_0513, 32'hFFFF_FFFC, 1'b0, 1'b0));
    sb.push_back(mk(32'h0010_0093, 32'h0000_0000, 1'b0, 1'b0));
    drive_fetch();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (instr_valid_o && instr_ready_i) begin
        n_chk++;
        o = {instr_rdata_o, instr_pc_o,
             instr_is_compressed_o, instr_err_o};
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL wrap instr: got %h want %h", o, e);
        end
      end
      advance();
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL wrap drain: got %0d left want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_compressed();
`ifdef IBEX_REALIGN_RVC_EN
    test_straddle();
`endif
    test_redirect();
    test_error();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
